rx_event_generator: RTL and testbench
=====================================

RX_EVENT_GENERATOR -- requirements
Module: rx_event_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of data / in_data.
REQ-002 Parameter BY_BYTE, default 1: 1 allows partial last byte on EOC; 0 means full bytes only, data_bits driven 0.
REQ-003 Parameter GAP_WIDTH, default 8: width of gap_cycles.
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream byte available.
REQ-007 in_ready  output  1  byte accepted when in_valid && in_ready at a rising edge.
REQ-008 in_data  input  DATA_WIDTH  byte payload, bit 0 first on air.
REQ-009 in_last  input  1  byte is the last of the frame.
REQ-010 in_bits  input  3  valid bits in last byte, 0 = full byte; ignored unless in_last && BY_BYTE.
REQ-011 in_error  input  1  emit an error event after this byte.
REQ-012 gap_cycles  input  GAP_WIDTH  idle cycles between consecutive events.
REQ-013 abort  input  1  terminate current frame with error.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 soc, eoc, error, data_valid  output  1 each  rx_interface event flags, single-cycle pulses.
REQ-016 data  output  DATA_WIDTH  event data; data_bits  output  3  valid bits of data.

Function
REQ-017 All outputs SHALL be registered; at most one event per cycle; soc never coincides with any other flag.
REQ-018 States: IDLE, SOC, GAP, FETCH, DATA, ERR, EOC.
REQ-019 IDLE: in_ready=0; in_valid=1 -> SOC next cycle; byte not consumed; gap_cycles latched on this transition, held for the whole frame.
REQ-020 SOC: soc=1 for one cycle -> GAP.
REQ-021 GAP: counter loaded with latched gap, decrements each cycle; at 0 -> pending target (FETCH, ERR or EOC); gap 0 SHALL give zero idle cycles between events.
REQ-022 FETCH: in_ready=1 combinationally from state; on handshake at edge N, data_valid=1 in cycle N+1 with data=in_data; state DATA.
REQ-023 Full-byte data event: data_bits=0, eoc=0, error=0.
REQ-024 in_last && BY_BYTE && in_bits!=0: the DATA cycle SHALL carry eoc=1, data_valid=1, data_bits=in_bits, unused data bits [7:in_bits] driven 0; then IDLE (in_error on that byte ignored).
REQ-025 After a non-final DATA: in_error=1 -> GAP then ERR; else GAP then FETCH.
REQ-026 After a final full-byte DATA: in_error=1 -> GAP, ERR, GAP, EOC; else GAP, EOC.
REQ-027 ERR: error=1 alone for one cycle. EOC: eoc=1 alone for one cycle -> IDLE.
REQ-028 FETCH with in_valid=0 SHALL wait indefinitely, no outputs.
REQ-029 abort=1 in any non-IDLE state: next cycle eoc=1, error=1, data_valid=0 simultaneously, then IDLE; pending byte not consumed; abort in IDLE ignored; abort wins over a simultaneous FETCH handshake (in_ready SHALL be 0 when abort=1).
REQ-030 in_last with in_bits=0 or BY_BYTE=0 SHALL be treated as full byte.
REQ-031 data/data_bits hold last value between events (don't-care when no flag set).

Reset
REQ-032 rst_n low: state IDLE, all flags 0, in_ready 0, busy 0, data 0, data_bits 0, gap counter 0, immediately and independent of clk.
REQ-033 Reset mid-frame SHALL drop the frame with no eoc emitted; first event after release is a new soc.

Verification
REQ-034 gap=0, bytes A5,3C (last) -> soc, dv A5, dv 3C, eoc on four consecutive cycles; busy 0 afterwards.
REQ-035 gap=2, byte 93 last, in_bits=7, BY_BYTE=1 -> soc, 2 idle, eoc+dv data=13 data_bits=7; no separate eoc.
REQ-036 gap=1, bytes 11 (in_error=1), 22 last -> soc, -, dv 11, -, error, -, dv 22, -, eoc.
REQ-037 abort asserted while FETCH waiting with in_valid=0 -> next cycle eoc=1 error=1, then IDLE, in_ready never asserted.
REQ-038 rst_n low for 1 cycle after dv of first byte -> all outputs 0 asynchronously; next frame starts with soc, no stray eoc.
REQ-039 BY_BYTE=0, in_last, in_bits=3 -> full-byte dv with data_bits=0, then separate eoc.

Source files
------------

// File: rtl/rx_event_generator.sv
// Turns a byte stream into rx_interface event pulses (soc, data, error, eoc)
// with a programmable number of idle cycles between consecutive events.
module rx_event_generator #(
  parameter int DATA_WIDTH = 8,
  parameter bit BY_BYTE    = 1'b1,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [2:0]            in_bits,
  input  logic                  in_error,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic                  abort,
  output logic                  busy,
  output logic                  soc,
  output logic                  eoc,
  output logic                  error,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [2:0]            data_bits
);

  typedef enum logic [2:0] {S_IDLE, S_SOC, S_GAP, S_FETCH, S_DATA, S_ERR, S_EOC} state_t;

  state_t                state_q, state_d;
  state_t                tgt_q, tgt_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  soc_q, soc_d;
  logic                  eoc_q, eoc_d;
  logic                  err_q, err_d;
  logic                  dv_q, dv_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [2:0]            bits_q, bits_d;

  logic                  fetch_now;
  logic                  hs;
  logic                  partial;
  logic                  emit_pend;
  logic [DATA_WIDTH-1:0] keep_mask;

  // With a zero gap the fetch overlaps the event cycle itself, so back-to-back
  // data events need no dedicated fetch cycle.
  assign fetch_now = (state_q == S_FETCH) ||
                     (((state_q == S_SOC) || (state_q == S_DATA) || (state_q == S_ERR)) &&
                      (tgt_q == S_FETCH) && (gap_q == '0));
  assign in_ready  = fetch_now && !abort;
  assign hs        = in_valid && in_ready;
  assign partial   = BY_BYTE && in_last && (in_bits != 3'd0);
  assign keep_mask = ~({DATA_WIDTH{1'b1}} << in_bits);

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    data_d    = data_q;
    bits_d    = bits_q;
    soc_d     = 1'b0;
    eoc_d     = 1'b0;
    err_d     = 1'b0;
    dv_d      = 1'b0;
    emit_pend = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SOC;
          soc_d   = 1'b1;
          gap_d   = gap_cycles;
          tgt_d   = S_FETCH;
          last_d  = 1'b0;
        end
      end
      S_SOC, S_DATA, S_ERR: begin
        if (tgt_q == S_FETCH) begin
          if (gap_q == '0) begin
            if (!hs) state_d = S_FETCH;
          end else if (gap_q == GAP_WIDTH'(1)) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_q - GAP_WIDTH'(1);
          end
        end else if (gap_q == '0) begin
          emit_pend = 1'b1;
        end else begin
          state_d = S_GAP;
          cnt_d   = gap_q;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_WIDTH'(1)) begin
          if (tgt_q == S_FETCH) state_d = S_FETCH;
          else                  emit_pend = 1'b1;
        end
        cnt_d = cnt_q - GAP_WIDTH'(1);
      end
      S_FETCH: ;
      S_EOC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (emit_pend) begin
      if (tgt_q == S_ERR) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        tgt_d   = last_q ? S_EOC : S_FETCH;
      end else begin
        state_d = S_EOC;
        eoc_d   = 1'b1;
      end
    end

    if (hs) begin
      dv_d = 1'b1;
      if (partial) begin
        state_d = S_EOC;
        eoc_d   = 1'b1;
        bits_d  = in_bits;
        data_d  = in_data & keep_mask;
      end else begin
        state_d = S_DATA;
        bits_d  = 3'd0;
        data_d  = in_data;
        last_d  = in_last;
        tgt_d   = in_error ? S_ERR : (in_last ? S_EOC : S_FETCH);
      end
    end

    // Abort overrides everything; in_ready is already low so no byte is taken.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_EOC;
      eoc_d   = 1'b1;
      err_d   = 1'b1;
      dv_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= S_IDLE;
      gap_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      soc_q   <= 1'b0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      bits_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      soc_q   <= soc_d;
      eoc_q   <= eoc_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
    end
  end

  assign soc        = soc_q;
  assign eoc        = eoc_q;
  assign error      = err_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
  assign data       = data_q;
  assign data_bits  = bits_q;

endmodule

// File: tb/tb_rx_event_generator.sv
// Bench for rx_event_generator: literal scenario checks plus randomized traffic
// compared every cycle against an event-timing model.
module tb_rx_event_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, in_error, abort;
  logic [7:0] in_data, gap_cycles;
  logic [2:0] in_bits;

  logic       rdy1, busy1, soc1, eoc1, err1, dv1;
  logic [7:0] data1;
  logic [2:0] bits1;
  logic       rdy0, busy0, soc0, eoc0, err0, dv0;
  logic [7:0] data0;
  logic [2:0] bits0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rx_event_generator #(.DATA_WIDTH(8), .BY_BYTE(1'b1), .GAP_WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .in_bits(in_bits), .in_error(in_error), .gap_cycles(gap_cycles),
    .abort(abort), .busy(busy1), .soc(soc1), .eoc(eoc1), .error(err1),
    .data_valid(dv1), .data(data1), .data_bits(bits1));

  rx_event_generator #(.DATA_WIDTH(8), .BY_BYTE(1'b0), .GAP_WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .in_bits(in_bits), .in_error(in_error), .gap_cycles(gap_cycles),
    .abort(abort), .busy(busy0), .soc(soc0), .eoc(eoc0), .error(err0),
    .data_valid(dv0), .data(data0), .data_bits(bits0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Event-timing model: each event occupies a cycle number; the next event may
  // appear no earlier than gap+1 cycles later. A data event needs the byte to
  // be taken in the cycle before it, which is allowed from last_ev+gap onward.
  localparam int K_NONE = 0, K_DATA = 1, K_ERR = 2, K_EOC = 3;
  int       cyc, m_last_ev, m_gap, m_kind;
  bit       m_busy, m_err_eoc, m_took;
  bit       m_soc, m_dv, m_er, m_eoc;
  logic [7:0] m_data;
  logic [2:0] m_bits;

  function automatic bit m_rdy();
    return m_busy && (m_kind == K_DATA) && (cyc >= m_last_ev + m_gap) && !abort;
  endfunction

  task automatic model_step();
    bit rdy;
    if (!rst_n) begin
      cyc = 0; m_last_ev = 0; m_gap = 0; m_kind = K_NONE;
      m_busy = 0; m_err_eoc = 0; m_took = 0;
      m_soc = 0; m_dv = 0; m_er = 0; m_eoc = 0; m_data = 0; m_bits = 0;
      return;
    end
    rdy = m_rdy();
    m_took = 0;
    m_soc = 0; m_dv = 0; m_er = 0; m_eoc = 0;
    if (!m_busy) begin
      if (in_valid) begin
        m_soc = 1; m_busy = 1; m_gap = int'(gap_cycles);
        m_last_ev = cyc + 1; m_kind = K_DATA; m_err_eoc = 0;
      end
    end else if (abort) begin
      m_eoc = 1; m_er = 1; m_kind = K_NONE;
    end else if (m_kind == K_NONE) begin
      m_busy = 0;
    end else if (m_kind == K_DATA) begin
      if (rdy && in_valid) begin
        m_took = 1; m_dv = 1; m_last_ev = cyc + 1;
        if (in_last && in_bits != 0) begin
          m_eoc = 1; m_bits = in_bits; m_kind = K_NONE;
          m_data = 8'(int'(in_data) % (1 << int'(in_bits)));
        end else begin
          m_bits = 0; m_data = in_data; m_err_eoc = in_last;
          m_kind = in_error ? K_ERR : (in_last ? K_EOC : K_DATA);
        end
      end
    end else if (cyc == m_last_ev + m_gap) begin
      m_last_ev = cyc + 1;
      if (m_kind == K_ERR) begin
        m_er = 1; m_kind = m_err_eoc ? K_EOC : K_DATA;
      end else begin
        m_eoc = 1; m_kind = K_NONE;
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison of the BY_BYTE=1 instance against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("cycle_flags", 32'({soc1, dv1, err1, eoc1, busy1, rdy1}),
          32'({m_soc, m_dv, m_er, m_eoc, m_busy, m_rdy()}));
      if (m_dv) chk("cycle_data", 32'({data1, bits1}), 32'({m_data, m_bits}));
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_zero1"}, 32'({soc1, dv1, err1, eoc1, busy1, rdy1, data1, bits1}), 32'd0);
    chk({tag, "_zero0"}, 32'({soc0, dv0, err0, eoc0, busy0, rdy0, data0, bits0}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  // ef = {soc, dv, error, eoc}; sel picks the BY_BYTE=0 instance.
  task automatic step(input string tag, input bit v, input logic [7:0] d, input bit l,
                      input logic [2:0] b, input bit e, input bit ab, input logic [7:0] g,
                      input logic [3:0] ef, input logic [7:0] ed, input logic [2:0] eb,
                      input bit ebusy, input bit erdy, input bit sel);
    logic [5:0] act;
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_last = l; in_bits = b; in_error = e;
    abort = ab; gap_cycles = g;
    @(negedge clk);
    act = sel ? {soc0, dv0, err0, eoc0, busy0, rdy0} : {soc1, dv1, err1, eoc1, busy1, rdy1};
    chk({tag, "_flags"}, 32'(act), 32'({ef, ebusy, erdy}));
    if (ef[2]) chk({tag, "_data"}, sel ? 32'({data0, bits0}) : 32'({data1, bits1}), 32'({ed, eb}));
    if (!sel) chk({tag, "_model"}, 32'({m_soc, m_dv, m_er, m_eoc, m_busy, m_rdy()}),
                  32'({ef, ebusy, erdy}));
  endtask

  task automatic new_byte();
    in_data  = 8'($urandom_range(0, 255));
    in_last  = ($urandom_range(0, 3) == 0);
    in_bits  = 3'($urandom_range(0, 7));
    in_error = ($urandom_range(0, 5) == 0);
  endtask

  initial begin
    in_valid = 0; in_data = 0; in_last = 0; in_bits = 0; in_error = 0;
    abort = 0; gap_cycles = 0; rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    chk_zero("por");
    rst_n = 1'b1;

    // gap 0, A5 then 3C last: soc, dv, dv, eoc back to back
    step("b2b", 1, 8'hA5, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    step("b2b", 1, 8'hA5, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 1, 1, 0);
    step("b2b", 1, 8'h3C, 1, 0, 0, 0, 0, 4'b0100, 8'hA5, 0, 1, 1, 0);
    step("b2b", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0100, 8'h3C, 0, 1, 0, 0);
    step("b2b", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 0);
    step("b2b", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

    // gap 2, partial last byte 93 with 7 bits -> eoc+dv, data 13
    step("part", 1, 8'h93, 1, 7, 0, 0, 2, 4'b0000, 0, 0, 0, 0, 0);
    step("part", 1, 8'h93, 1, 7, 0, 0, 2, 4'b1000, 0, 0, 1, 0, 0);
    step("part", 1, 8'h93, 1, 7, 0, 0, 2, 4'b0000, 0, 0, 1, 0, 0);
    step("part", 1, 8'h93, 1, 7, 0, 0, 2, 4'b0000, 0, 0, 1, 1, 0);
    step("part", 0, 8'h00, 0, 0, 0, 0, 2, 4'b0101, 8'h13, 7, 1, 0, 0);
    step("part", 0, 8'h00, 0, 0, 0, 0, 2, 4'b0000, 0, 0, 0, 0, 0);

    // gap 1, 11 with error, 22 last
    step("errf", 1, 8'h11, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0, 0);
    step("errf", 1, 8'h11, 0, 0, 1, 0, 1, 4'b1000, 0, 0, 1, 0, 0);
    step("errf", 1, 8'h11, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 1, 1, 0);
    step("errf", 1, 8'h22, 1, 0, 0, 0, 1, 4'b0100, 8'h11, 0, 1, 0, 0);
    step("errf", 1, 8'h22, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0);
    step("errf", 1, 8'h22, 1, 0, 0, 0, 1, 4'b0010, 0, 0, 1, 0, 0);
    step("errf", 1, 8'h22, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 1, 0);
    step("errf", 0, 8'h00, 0, 0, 0, 0, 1, 4'b0100, 8'h22, 0, 1, 0, 0);
    step("errf", 0, 8'h00, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 1, 0, 0);
    step("errf", 0, 8'h00, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 1, 0, 0);
    step("errf", 0, 8'h00, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 0, 0);

    // abort while waiting in fetch with no data offered
    step("abrt", 1, 8'h44, 0, 0, 0, 0, 2, 4'b0000, 0, 0, 0, 0, 0);
    step("abrt", 0, 8'h44, 0, 0, 0, 0, 2, 4'b1000, 0, 0, 1, 0, 0);
    step("abrt", 0, 8'h44, 0, 0, 0, 0, 2, 4'b0000, 0, 0, 1, 0, 0);
    step("abrt", 0, 8'h44, 0, 0, 0, 1, 2, 4'b0000, 0, 0, 1, 0, 0);
    step("abrt", 0, 8'h44, 0, 0, 0, 0, 2, 4'b0011, 0, 0, 1, 0, 0);
    step("abrt", 0, 8'h44, 0, 0, 0, 0, 2, 4'b0000, 0, 0, 0, 0, 0);

    // reset mid-frame, then a fresh frame starting with soc
    step("rstm", 1, 8'h55, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);
    step("rstm", 1, 8'h55, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 1, 1, 0);
    step("rstm", 1, 8'h66, 1, 0, 0, 0, 0, 4'b0100, 8'h55, 0, 1, 1, 0);
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    @(posedge clk); @(negedge clk); #2;
    rst_n = 1'b1;
    step("rstm", 1, 8'h66, 1, 0, 0, 0, 0, 4'b1000, 0, 0, 1, 1, 0);
    step("rstm", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0100, 8'h66, 0, 1, 0, 0);
    step("rstm", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 0);
    step("rstm", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0);

    // whole-byte instance: in_bits ignored, separate eoc
    do_reset();
    step("full", 1, 8'h5A, 1, 3, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1);
    step("full", 1, 8'h5A, 1, 3, 0, 0, 0, 4'b1000, 0, 0, 1, 1, 1);
    step("full", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0100, 8'h5A, 0, 1, 0, 1);
    step("full", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 1, 0, 1);
    step("full", 0, 8'h00, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1);

    // randomized traffic with stalls, aborts and occasional resets
    do_reset();
    new_byte();
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (m_took) new_byte();
      in_valid   = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 59) == 0);
      gap_cycles = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 12))
                                               : 8'($urandom_range(0, 3));
      if ((i % 900) == 450) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_rand");
        @(negedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
      end
    end
    in_valid = 0; abort = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
